// File: rtl/quiz_pkg.sv
// Shared state codes and width helpers for the multi-player quiz controller.
package quiz_pkg;

    typedef enum logic [3:0] {
        ST_INICIAL    = 4'h0,
        ST_PREPARACAO = 4'h1,
        ST_AGUARDA    = 4'h5,
        ST_REGISTRA   = 4'h6,
        ST_COMPARA    = 4'h7,
        ST_PROXIMA    = 4'h8,
        ST_ACERTO     = 4'hC,
        ST_TIMEOUT    = 4'hD,
        ST_ERRO       = 4'hE,
        ST_FIM        = 4'hF
    } estado_t;

    localparam logic [3:0] DB_INVALIDO = 4'hB;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/quiz_controller_mp_if.sv
// Board/datapath-facing signal bundle of the quiz controller.
interface quiz_controller_mp_if #(
    parameter int N_PLAYERS = 2,
    parameter int N_ROUNDS  = 16,
    parameter int SCORE_W   = 5
);
    localparam int PW = quiz_pkg::clog2_min1(N_PLAYERS);
    localparam int RW = quiz_pkg::clog2_min1(N_ROUNDS + 1);

    logic                         iniciar;
    logic                         modo_treino;
    logic                         fez_jogada;
    logic                         jogada_igual_memoria;
    logic                         registraR;
    logic                         zeraR;
    logic                         liga_led;
    logic                         acertou;
    logic                         errou;
    logic                         timeout;
    logic                         pronto;
    logic [PW-1:0]                jogador_atual;
    logic [RW-1:0]                rodada;
    logic [N_PLAYERS*SCORE_W-1:0] scores;
    logic [PW-1:0]                vencedor;
    logic                         empate;
    logic [3:0]                   db_estado;

    modport master (
        output iniciar, modo_treino, fez_jogada, jogada_igual_memoria,
        input  registraR, zeraR, liga_led, acertou, errou, timeout, pronto,
               jogador_atual, rodada, scores, vencedor, empate, db_estado
    );

    modport slave (
        input  iniciar, modo_treino, fez_jogada, jogada_igual_memoria,
        output registraR, zeraR, liga_led, acertou, errou, timeout, pronto,
               jogador_atual, rodada, scores, vencedor, empate, db_estado
    );
endinterface

// File: rtl/game_timer.sv
// Cycle counter with synchronous clear; fim flags the count LIMIT-1.
module game_timer #(
    parameter int LIMIT = 4,
    parameter int W     = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zera,
    input  logic         conta,
    output logic         fim,
    output logic [W-1:0] valor
);
    logic [W-1:0] valor_q, valor_d;

    always_comb begin
        valor_d = valor_q;
        if (zera)
            valor_d = '0;
        else if (conta)
            valor_d = valor_q + W'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            valor_q <= '0;
        else
            valor_q <= valor_d;
    end

    assign valor = valor_q;
    assign fim   = (valor_q == W'(LIMIT - 1));
endmodule

// File: rtl/quiz_controller_mp.sv
// Multi-player quiz control unit: rotating turns, per-player scores/errors,
// answer timeout and result display timing, winner/tie detection.
module quiz_controller_mp
    import quiz_pkg::*;
#(
    parameter int N_PLAYERS   = 2,
    parameter int N_ROUNDS    = 16,
    parameter int TIMEOUT_CYC = 5000,
    parameter int RESULT_CYC  = 2000,
    parameter int MAX_ERRORS  = 3,
    parameter int SCORE_W     = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    quiz_controller_mp_if.slave  bus
);
    localparam int PW = clog2_min1(N_PLAYERS);
    localparam int RW = clog2_min1(N_ROUNDS + 1);
    localparam int TW = clog2_min1(TIMEOUT_CYC);
    localparam int DW = clog2_min1(RESULT_CYC);
    localparam int EW = clog2_min1(MAX_ERRORS + 1);

    estado_t           state_q, state_d;
    logic [PW-1:0]     jogador_q, jogador_d;
    logic [RW-1:0]     rodada_q, rodada_d;
    logic              treino_q, treino_d;
    logic [SCORE_W-1:0] score_q [N_PLAYERS];
    logic [SCORE_W-1:0] score_d [N_PLAYERS];
    logic [EW-1:0]     err_q [N_PLAYERS];
    logic [EW-1:0]     err_d [N_PLAYERS];

    logic          em_resultado;
    logic          tmo_fim, res_fim;
    logic [TW-1:0] tmo_valor;
    logic [DW-1:0] res_valor;
    logic          tmo_expira, res_expira;

    assign em_resultado = (state_q == ST_ACERTO) || (state_q == ST_ERRO) ||
                          (state_q == ST_TIMEOUT);

    // Timers hold at their last count instead of wrapping (practice mode idles in AGUARDA).
    game_timer #(.LIMIT(TIMEOUT_CYC), .W(TW)) u_tmo (
        .clock (clock),
        .reset (reset),
        .zera  (state_q != ST_AGUARDA),
        .conta ((state_q == ST_AGUARDA) && !tmo_fim),
        .fim   (tmo_fim),
        .valor (tmo_valor)
    );

    game_timer #(.LIMIT(RESULT_CYC), .W(DW)) u_res (
        .clock (clock),
        .reset (reset),
        .zera  (!em_resultado),
        .conta (em_resultado && !res_fim),
        .fim   (res_fim),
        .valor (res_valor)
    );

    assign tmo_expira = (tmo_valor == TW'(TIMEOUT_CYC - 1));
    assign res_expira = (res_valor == DW'(RESULT_CYC - 1));

    always_comb begin
        state_d   = state_q;
        jogador_d = jogador_q;
        rodada_d  = rodada_q;
        treino_d  = treino_q;
        score_d   = score_q;
        err_d     = err_q;
        case (state_q)
            ST_INICIAL: if (bus.iniciar) state_d = ST_PREPARACAO;
            ST_PREPARACAO: begin
                jogador_d = '0;
                rodada_d  = '0;
                treino_d  = bus.modo_treino;
                for (int p = 0; p < N_PLAYERS; p++) begin
                    score_d[p] = '0;
                    err_d[p]   = '0;
                end
                state_d = ST_AGUARDA;
            end
            ST_AGUARDA: begin
                if (bus.fez_jogada) begin
                    state_d = ST_REGISTRA;
                end else if (!treino_q && tmo_expira) begin
                    state_d = ST_TIMEOUT;
                    if (err_q[jogador_q] != '1) err_d[jogador_q] = err_q[jogador_q] + EW'(1);
                end
            end
            ST_REGISTRA: state_d = ST_COMPARA;
            ST_COMPARA: begin
                if (bus.jogada_igual_memoria) begin
                    state_d = ST_ACERTO;
                    if (score_q[jogador_q] != '1)
                        score_d[jogador_q] = score_q[jogador_q] + SCORE_W'(1);
                end else begin
                    state_d = ST_ERRO;
                    if (err_q[jogador_q] != '1) err_d[jogador_q] = err_q[jogador_q] + EW'(1);
                end
            end
            ST_ACERTO, ST_ERRO, ST_TIMEOUT: begin
                if (res_expira) begin
                    if ((MAX_ERRORS != 0) && (err_q[jogador_q] >= EW'(MAX_ERRORS))) begin
                        state_d = ST_FIM;
                    end else if ((jogador_q == PW'(N_PLAYERS - 1)) &&
                                 (rodada_q == RW'(N_ROUNDS - 1))) begin
                        state_d  = ST_FIM;
                        rodada_d = rodada_q + RW'(1);
                    end else begin
                        state_d = ST_PROXIMA;
                    end
                end
            end
            ST_PROXIMA: begin
                if (jogador_q == PW'(N_PLAYERS - 1)) begin
                    jogador_d = '0;
                    rodada_d  = rodada_q + RW'(1);
                end else begin
                    jogador_d = jogador_q + PW'(1);
                end
                state_d = ST_AGUARDA;
            end
            ST_FIM: if (bus.iniciar) state_d = ST_PREPARACAO;
            default: state_d = ST_INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_INICIAL;
            jogador_q <= '0;
            rodada_q  <= '0;
            treino_q  <= 1'b0;
            for (int p = 0; p < N_PLAYERS; p++) begin
                score_q[p] <= '0;
                err_q[p]   <= '0;
            end
        end else begin
            state_q   <= state_d;
            jogador_q <= jogador_d;
            rodada_q  <= rodada_d;
            treino_q  <= treino_d;
            score_q   <= score_d;
            err_q     <= err_d;
        end
    end

    // Moore outputs decoded from the state register.
    logic [3:0] db_estado;
    always_comb begin
        db_estado = state_q;
        case (state_q)
            ST_INICIAL, ST_PREPARACAO, ST_AGUARDA, ST_REGISTRA, ST_COMPARA,
            ST_PROXIMA, ST_ACERTO, ST_TIMEOUT, ST_ERRO, ST_FIM: db_estado = state_q;
            default: db_estado = DB_INVALIDO;
        endcase
    end

    // Highest score wins; strict '>' keeps the lowest index on a tie.
    logic [SCORE_W-1:0]         melhor;
    logic [PW-1:0]              vencedor;
    logic                       empate, visto;
    logic [N_PLAYERS*SCORE_W-1:0] scores_flat;
    always_comb begin
        melhor      = score_q[0];
        vencedor    = '0;
        empate      = 1'b0;
        visto       = 1'b0;
        scores_flat = '0;
        for (int p = 1; p < N_PLAYERS; p++) begin
            if (score_q[p] > melhor) begin
                melhor   = score_q[p];
                vencedor = PW'(p);
            end
        end
        for (int p = 0; p < N_PLAYERS; p++) begin
            if (score_q[p] == melhor) begin
                if (visto) empate = 1'b1;
                visto = 1'b1;
            end
            scores_flat[p*SCORE_W +: SCORE_W] = score_q[p];
        end
    end

    assign bus.registraR     = (state_q == ST_REGISTRA);
    assign bus.zeraR         = (state_q == ST_INICIAL) || (state_q == ST_PROXIMA) || em_resultado;
    assign bus.liga_led      = (state_q == ST_AGUARDA);
    assign bus.acertou       = (state_q == ST_ACERTO);
    assign bus.errou         = (state_q == ST_ERRO);
    assign bus.timeout       = (state_q == ST_TIMEOUT);
    assign bus.pronto        = (state_q == ST_FIM);
    assign bus.jogador_atual = jogador_q;
    assign bus.rodada        = rodada_q;
    assign bus.scores        = scores_flat;
    assign bus.vencedor      = vencedor;
    assign bus.empate        = empate;
    assign bus.db_estado     = db_estado;
endmodule

// File: tb/tb_quiz_controller_mp.sv
// Scoreboarded bench for quiz_controller_mp: turn results are queued as answers are
// driven and matched when the controller enters a result state.
module tb_quiz_controller_mp;
    localparam int NP = 2;
    localparam int NR = 2;
    localparam int TC = 8;
    localparam int RC = 4;
    localparam int ME = 2;
    localparam int SW = 3;

    localparam logic [3:0] S_INI = 4'h0, S_PREP = 4'h1, S_AGU = 4'h5, S_REG = 4'h6,
                           S_ACE = 4'hC, S_TMO = 4'hD, S_ERR = 4'hE, S_FIM = 4'hF;

    logic clock = 1'b0;
    logic reset = 1'b0;

    quiz_controller_mp_if #(.N_PLAYERS(NP), .N_ROUNDS(NR), .SCORE_W(SW)) qif ();

    quiz_controller_mp #(
        .N_PLAYERS(NP), .N_ROUNDS(NR), .TIMEOUT_CYC(TC),
        .RESULT_CYC(RC), .MAX_ERRORS(ME), .SCORE_W(SW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (qif)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] code;
        logic [3:0] player;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every entry into a result state must match the next queued turn.
    logic [3:0] prev_db = 4'h0;
    always @(negedge clock) begin
        exp_t e;
        if (reset && (qif.db_estado inside {S_ACE, S_TMO, S_ERR}) && (qif.db_estado != prev_db)) begin
            if (sb.size() == 0) begin
                check_eq("sb_unexpected_result", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check_eq("result_code", 32'(qif.db_estado), 32'(e.code));
                check_eq("result_player", 32'(qif.jogador_atual), 32'(e.player));
            end
        end
        prev_db = qif.db_estado;
    end

    task automatic wait_state(input logic [3:0] code, input string tag);
        for (int i = 0; i < 60; i++) begin
            if (qif.db_estado == code) break;
            @(negedge clock);
        end
        check_eq(tag, 32'(qif.db_estado), 32'(code));
    endtask

    task automatic start_game(input logic treino);
        qif.modo_treino = treino;
        qif.iniciar     = 1'b1;
        @(negedge clock);
        check_eq("enter_prep", 32'(qif.db_estado), 32'(S_PREP));
        qif.iniciar = 1'b0;
    endtask

    task automatic play_turn(input int player, input logic correct);
        exp_t e;
        wait_state(S_AGU, "turn_wait_aguarda");
        check_eq("turn_player", 32'(qif.jogador_atual), 32'(player));
        e.code   = correct ? S_ACE : S_ERR;
        e.player = 4'(player);
        sb.push_back(e);
        qif.jogada_igual_memoria = correct;
        qif.fez_jogada           = 1'b1;
        @(negedge clock);
        qif.fez_jogada = 1'b0;
        check_eq("registra_pulse", 32'(qif.registraR), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got no end, expected end");
        $fatal(1);
    end

    initial begin
        int   n;
        exp_t e;
        qif.iniciar              = 1'b0;
        qif.modo_treino          = 1'b0;
        qif.fez_jogada           = 1'b0;
        qif.jogada_igual_memoria = 1'b0;
        repeat (3) @(negedge clock);

        // Reset values
        check_eq("rst_db", 32'(qif.db_estado), 32'(S_INI));
        check_eq("rst_zeraR", 32'(qif.zeraR), 32'd1);
        check_eq("rst_leds", 32'({qif.registraR, qif.liga_led, qif.acertou, qif.errou,
                                  qif.timeout, qif.pronto}), 32'd0);
        check_eq("rst_counters", 32'({qif.scores, qif.jogador_atual, qif.rodada}), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        check_eq("idle_without_iniciar", 32'(qif.db_estado), 32'(S_INI));

        // Game A: four correct answers, tie at 2-2
        start_game(1'b0);
        play_turn(0, 1'b1);
        play_turn(1, 1'b1);
        play_turn(0, 1'b1);
        play_turn(1, 1'b1);
        wait_state(S_FIM, "a_fim");
        check_eq("a_scores", 32'(qif.scores), 32'((2 << SW) | 2));
        check_eq("a_empate", 32'(qif.empate), 32'd1);
        check_eq("a_vencedor", 32'(qif.vencedor), 32'd0);
        check_eq("a_rodada", 32'(qif.rodada), 32'd2);
        check_eq("a_pronto", 32'(qif.pronto), 32'd1);

        // Restart from FIM, then Game B: P0 times out, P1 right, P0 wrong -> error limit
        start_game(1'b0);
        @(negedge clock);
        check_eq("restart_aguarda", 32'(qif.db_estado), 32'(S_AGU));
        check_eq("restart_scores", 32'(qif.scores), 32'd0);
        e.code = S_TMO; e.player = 4'd0;
        sb.push_back(e);
        n = 0;
        while (qif.db_estado != S_TMO && n < 40) begin
            @(negedge clock);
            n++;
        end
        check_eq("timeout_latency", 32'(n), 32'(TC));
        n = 0;
        while (qif.timeout == 1'b1 && n < 20) begin
            n++;
            @(negedge clock);
        end
        check_eq("timeout_led_cycles", 32'(n), 32'(RC));
        play_turn(1, 1'b1);
        play_turn(0, 1'b0);
        wait_state(S_FIM, "b_fim");
        check_eq("b_rodada", 32'(qif.rodada), 32'd1);
        check_eq("b_scores", 32'(qif.scores), 32'(1 << SW));
        check_eq("b_vencedor", 32'(qif.vencedor), 32'd1);
        check_eq("b_empate", 32'(qif.empate), 32'd0);

        // Game C: P0 wrong on turns 1 and 3
        start_game(1'b0);
        play_turn(0, 1'b0);
        play_turn(1, 1'b1);
        play_turn(0, 1'b0);
        wait_state(S_ERR, "c_second_erro");
        n = 0;
        while (qif.db_estado == S_ERR && n < 20) begin
            n++;
            @(negedge clock);
        end
        check_eq("c_erro_cycles", 32'(n), 32'(RC));
        check_eq("c_fim_after_erro", 32'(qif.db_estado), 32'(S_FIM));
        check_eq("c_rodada", 32'(qif.rodada), 32'd1);
        check_eq("c_scores", 32'(qif.scores), 32'(1 << SW));

        // Game D: practice mode never times out (mode latched, input dropped afterwards)
        start_game(1'b1);
        wait_state(S_AGU, "d_aguarda");
        qif.modo_treino = 1'b0;
        repeat (100) @(negedge clock);
        check_eq("d_still_aguarda", 32'(qif.db_estado), 32'(S_AGU));
        check_eq("d_led", 32'({qif.liga_led, qif.timeout}), 32'b10);
        reset = 1'b0;
        #1;
        check_eq("d_async_reset", 32'(qif.db_estado), 32'(S_INI));
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Game E: answer on the expiry cycle wins, then reset mid-ACERTO
        start_game(1'b0);
        wait_state(S_AGU, "e_aguarda");
        repeat (TC - 1) @(negedge clock);
        e.code = S_ACE; e.player = 4'd0;
        sb.push_back(e);
        qif.jogada_igual_memoria = 1'b1;
        qif.fez_jogada           = 1'b1;
        @(negedge clock);
        qif.fez_jogada = 1'b0;
        check_eq("e_answer_wins", 32'(qif.db_estado), 32'(S_REG));
        wait_state(S_ACE, "e_acerto");
        @(negedge clock);
        check_eq("e_score_before_reset", 32'(qif.scores), 32'd1);
        reset = 1'b0;
        #1;
        check_eq("e_rst_db", 32'(qif.db_estado), 32'(S_INI));
        check_eq("e_rst_zeraR", 32'(qif.zeraR), 32'd1);
        check_eq("e_rst_leds", 32'({qif.registraR, qif.liga_led, qif.acertou, qif.errou,
                                    qif.timeout, qif.pronto}), 32'd0);
        check_eq("e_rst_counters", 32'({qif.scores, qif.jogador_atual, qif.rodada}), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_eq("e_idle_after_reset", 32'(qif.db_estado), 32'(S_INI));

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
